mask_index_expander: RTL
========================

// Module: mask_index_expander
// PURPOSE
//  Inverse of the 32:1 mask popcount tree: instead of collapsing a mask into a count, expands a
//  VL-bit element mask into a stream of set-bit indices, lowest first, one per cycle.
//  Each beat carries the element index and its rank (its ordinal among the set bits).
//  Sits in the vector permutation unit; feeds vcompress/viota destination-slot generation.
// PARAMETERS
//  VL     32            mask width, in elements (power of 2, >=2)
//  IDX_W  $clog2(VL)    index/rank width; derived, never overridden
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      mask offered
//  in_ready   out  1      expander idle, mask can be accepted
//  in_mask    in   VL     element mask, bit i = element i active
//  out_valid  out  1      index beat valid
//  out_ready  in   1      consumer takes beat
//  out_idx    out  IDX_W  element index of the current set bit
//  out_rank   out  IDX_W  number of set bits below out_idx
//  out_empty  out  1      beat reports an all-zero mask (out_idx/out_rank = 0)
//  out_last   out  1      final beat of this mask
// BEHAVIOUR
//  - Reset: state=IDLE, mask_q=0, rank_q=0; in_ready=1; out_valid/out_empty/out_last=0; idx/rank=0.
//  - FSM IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: mask_q<=in_mask, rank_q<=0;
//    next = EMPTY if in_mask==0, else SCAN.
//  - SCAN: in_ready=0, out_valid=1; out_idx = lowest set bit of mask_q (combinational);
//    out_rank=rank_q; out_last=1 iff mask_q has exactly one set bit.
//    On out_valid&out_ready: clear that bit in mask_q, rank_q++; if out_last -> IDLE.
//    Without out_ready: all outputs held stable (AXI-style, no retraction).
//  - EMPTY: one beat out_valid=1, out_empty=1, out_last=1, idx=rank=0; on handshake -> IDLE.
//  - Latency: mask accepted in cycle t -> first out_valid in t+1; N set bits -> N beats over
//    >=N cycles; next mask accepted no earlier than cycle after the last handshake (1 bubble).
//  - rank never wraps: max rank VL-1 fits IDX_W; all-ones mask emits VL beats, rank 0..VL-1.
//  - in_valid while busy is ignored (in_ready=0); input data need not be held after accept.
//  - rst asserted mid-stream: beat dropped, back to reset state next cycle, no partial last.
// CONFIGURATION
//  MASK_EXP_COUNT_EN defined: extra ports cnt_valid (out,1) and cnt (out,IDX_W+1); cnt_valid
//    pulses 1 cycle in the cycle after accept, cnt = popcount(in_mask) (0..VL).
//    Reset: cnt_valid=0, cnt=0.
//  Not defined: ports absent, no popcount logic; stream behaviour identical in both builds.
// STRUCTURE
//  Package mask_exp_pkg: VL_DEF, IDX_W_DEF constants; typedef idx_t; enum state_t {IDLE,SCAN,EMPTY}.
//  Sub-module lsb_prio_enc (VL -> IDX_W index + one-hot + single-bit flag), combinational.
//  Remaining logic (FSM, mask_q/rank_q, optional count) stays in this module.
// TESTING
//  1 mask 32'h0000_0091, out_ready=1 -> beats (idx,rank,last) (0,0,0)(4,1,0)(7,2,1), then in_ready=1.
//  2 mask 0 -> single beat out_empty=1,out_last=1,idx=0; in_ready back next cycle.
//  3 mask 32'hFFFF_FFFF -> 32 beats idx=rank=0..31, out_last only on idx 31.
//  4 mask 32'h8000_0001, out_ready toggling 1/0 -> idx/rank held while stalled; beats 0 then 31.
//  5 mask 32'h00F0_0000, rst after 2nd beat -> no 3rd beat, in_ready=1 and outputs 0 next cycle.
//  6 COUNT_EN: mask 32'h0F0F_0F0F -> cnt_valid pulse cycle t+1 with cnt=16; mask 0 -> cnt=0.

Source files
------------

// File: rtl/mask_exp_pkg.sv
// rtl/mask_exp_pkg.sv - shared constants and types for the mask index expander
// Purpose : default mask geometry and the expander FSM state type.
// Ports   : none (package).
package mask_exp_pkg;

   localparam int VL_DEF    = 32;
   localparam int IDX_W_DEF = $clog2(VL_DEF);

   typedef logic [IDX_W_DEF-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      EMPTY = 2'd2
   } state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - lowest-set-bit priority encoder
// Purpose : combinational LSB-first priority encode of a VL-bit vector.
// Ports   : vec_i     VL     vector to encode
//           idx_o     IDX_W  index of lowest set bit (0 when vec_i is zero)
//           onehot_o  VL     isolated lowest set bit
//           single_o  1      vec_i has exactly one bit set
module lsb_prio_enc #(
   parameter int VL    = 32,
   parameter int IDX_W = $clog2(VL)
) (
   input  logic [VL-1:0]    vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [VL-1:0]    onehot_o,
   output logic             single_o
);

   // Scan from the top down so the lowest set bit is the last writer.
   always_comb begin
      idx_o = '0;
      for (int i = VL - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IDX_W'(i);
      end
   end

   // Two's-complement trick: x & -x isolates the lowest set bit.
   assign onehot_o = vec_i & (~vec_i + VL'(1));

   // Clearing the lowest bit leaves zero only when one bit was set.
   assign single_o = (vec_i != '0) && ((vec_i & (vec_i - VL'(1))) == '0);

endmodule

// File: rtl/mask_index_expander.sv
// rtl/mask_index_expander.sv - expands an element mask into a stream of set-bit indices
// Purpose : accepts a VL-bit mask and emits one beat per set bit, lowest first,
//           carrying the element index and its rank; an all-zero mask yields a
//           single empty beat. Optional popcount side output under MASK_EXP_COUNT_EN.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           in_valid/in_ready/in_mask  mask input handshake
//           out_valid/out_ready        beat output handshake
//           out_idx, out_rank          element index and ordinal of the set bit
//           out_empty, out_last        all-zero mask beat, final beat of the mask
//           cnt_valid, cnt             (MASK_EXP_COUNT_EN only) popcount of accepted mask
module mask_index_expander
   import mask_exp_pkg::*;
#(
   parameter int VL = VL_DEF,
   localparam int IDX_W = $clog2(VL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VL-1:0]    in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [IDX_W-1:0] out_rank,
   output logic             out_empty,
   output logic             out_last
`ifdef MASK_EXP_COUNT_EN
   ,
   output logic             cnt_valid,
   output logic [IDX_W:0]   cnt
`endif
);

   state_t           state_q, state_d;
   logic [VL-1:0]    mask_q, mask_d;
   logic [IDX_W-1:0] rank_q, rank_d;

   logic [IDX_W-1:0] enc_idx;
   logic [VL-1:0]    enc_onehot;
   logic             enc_single;

   lsb_prio_enc #(
      .VL    (VL),
      .IDX_W (IDX_W)
   ) u_enc (
      .vec_i    (mask_q),
      .idx_o    (enc_idx),
      .onehot_o (enc_onehot),
      .single_o (enc_single)
   );

   // Outputs are pure functions of the registered state, so they cannot
   // change while a beat is stalled.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q != IDLE);
   assign out_idx   = (state_q == SCAN) ? enc_idx : '0;
   assign out_rank  = (state_q == SCAN) ? rank_q  : '0;
   assign out_empty = (state_q == EMPTY);
   assign out_last  = ((state_q == SCAN) && enc_single) || (state_q == EMPTY);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      rank_d  = rank_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mask_d  = in_mask;
               rank_d  = '0;
               state_d = (in_mask == '0) ? EMPTY : SCAN;
            end
         end
         SCAN: begin
            if (out_ready) begin
               mask_d = mask_q & ~enc_onehot;
               rank_d = rank_q + IDX_W'(1);
               if (enc_single) state_d = IDLE;
            end
         end
         EMPTY: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
         rank_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         rank_q  <= rank_d;
      end
   end

`ifdef MASK_EXP_COUNT_EN
   logic [IDX_W:0] cnt_d, cnt_q;
   logic           cnt_valid_q;

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < VL; i++) begin
         cnt_d = cnt_d + (IDX_W + 1)'(in_mask[i]);
      end
   end

   // Count is captured on the accepting edge and reported for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         cnt_valid_q <= in_valid && in_ready;
         if (in_valid && in_ready) cnt_q <= cnt_d;
      end
   end

   assign cnt_valid = cnt_valid_q;
   assign cnt       = cnt_q;
`endif

endmodule
